// File: rtl/data_memory_ctrl.sv
// Synchronous word-addressed data memory with valid/ready requests, byte enables,
// a one-cycle registered response and a hardware zero-fill sequencer.
module data_memory_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [DATA_W/8-1:0] req_be,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                init_done
);

  localparam int unsigned NumBytes = DATA_W / 8;
  localparam int unsigned IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DEPTH - 1);

  typedef enum logic [0:0] {StInit, StIdle} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] cnt_q, cnt_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              in_range;
  logic [IdxW-1:0]   idx;

  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;

  assign req_ready = (state_q == StIdle);
  assign init_done = (state_q == StIdle);
  assign accept    = req_valid && req_ready;
  assign in_range  = 64'(req_addr) < 64'(DEPTH);
  assign idx       = req_addr[IdxW-1:0];

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StInit: begin
        if (cnt_q == LastIdx) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StIdle: begin
        // A request accepted alongside clr still completes; the clear starts next edge.
        if (clr) begin
          state_d = StInit;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StInit;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StInit;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == StInit) begin
      mem[cnt_q] <= '0;
    end else if (accept && req_wen && in_range) begin
      for (int i = 0; i < NumBytes; i++) begin
        if (req_be[i]) begin
          mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

  // rdata/err only move on an accepted request so they hold between responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= accept;
      if (accept) begin
        rsp_err_q   <= !in_range;
        rsp_rdata_q <= (!req_wen && in_range) ? mem[idx] : '0;
      end
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench: a DEPTH=256 and a DEPTH=200 instance share stimulus, each with
// its own reference memory and expected-response queue.
module tb_data_memory_ctrl;

  logic        clk;
  logic        rst;
  logic        clr;
  logic        req_valid;
  logic        req_wen;
  logic [3:0]  req_be;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;

  logic        req_ready,   req_ready_s;
  logic        rsp_valid,   rsp_valid_s;
  logic [31:0] rsp_rdata,   rsp_rdata_s;
  logic        rsp_err,     rsp_err_s;
  logic        init_done,   init_done_s;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } rsp_t;

  rsp_t        q_big[$];
  rsp_t        q_sm[$];
  logic [31:0] m_big [256];
  logic [31:0] m_sm  [256];
  int          cyc;
  int          n_checks;
  int          n_errors;

  data_memory_ctrl #(.DATA_W(32), .ADDR_W(8), .DEPTH(256)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wen   (req_wen),
    .req_be    (req_be),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .init_done (init_done)
  );

  data_memory_ctrl #(.DATA_W(32), .ADDR_W(8), .DEPTH(200)) dut_s (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .req_valid (req_valid),
    .req_ready (req_ready_s),
    .req_wen   (req_wen),
    .req_be    (req_be),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid_s),
    .rsp_rdata (rsp_rdata_s),
    .rsp_err   (rsp_err_s),
    .init_done (init_done_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic zero_models();
    for (int i = 0; i < 256; i++) begin
      m_big[i] = '0;
      m_sm[i]  = '0;
    end
  endtask

  // Drive one request for a single cycle and record both expected responses.
  task automatic send(input logic wen, input logic [3:0] be, input logic [7:0] addr,
                      input logic [31:0] wdata, input logic do_clr);
    rsp_t e;
    req_valid = 1'b1;
    req_wen   = wen;
    req_be    = be;
    req_addr  = addr;
    req_wdata = wdata;
    clr       = do_clr;
    check("ready_big", {31'b0, req_ready}, 32'd1);
    check("ready_sm", {31'b0, req_ready_s}, 32'd1);
    e.cyc = cyc + 1;
    e.err = 1'b0;
    e.rdata = wen ? 32'h0 : m_big[addr];
    if (wen) begin
      for (int i = 0; i < 4; i++) if (be[i]) m_big[addr][8*i +: 8] = wdata[8*i +: 8];
    end
    q_big.push_back(e);
    if (addr >= 8'd200) begin
      e.rdata = '0;
      e.err   = 1'b1;
    end else begin
      e.err   = 1'b0;
      e.rdata = wen ? 32'h0 : m_sm[addr];
      if (wen) begin
        for (int i = 0; i < 4; i++) if (be[i]) m_sm[addr][8*i +: 8] = wdata[8*i +: 8];
      end
    end
    q_sm.push_back(e);
    if (do_clr) zero_models();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    req_wen   = 1'b0;
    clr       = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Counts rising edges until init_done rises on each instance.
  task automatic wait_init(input int exp_big, input int exp_sm);
    int nb;
    int ns;
    nb = -1;
    ns = -1;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk);
      #1;
      if (ns < 0 && init_done_s) ns = i;
      if (nb < 0 && init_done) nb = i;
      if (nb >= 0 && ns >= 0) break;
    end
    check("init_len_big", nb, exp_big);
    check("init_len_sm", ns, exp_sm);
  endtask

  task automatic drain();
    check("drain_big", q_big.size(), 32'd0);
    check("drain_sm", q_sm.size(), 32'd0);
  endtask

  always @(negedge clk) begin
    rsp_t e;
    if (!rst) begin
      if (rsp_valid) begin
        if (q_big.size() == 0) begin
          check("big_unexp", {31'b0, rsp_valid}, 32'd0);
        end else begin
          e = q_big.pop_front();
          check("big_rdata", rsp_rdata, e.rdata);
          check("big_err", {31'b0, rsp_err}, {31'b0, e.err});
          check("big_lat", cyc, e.cyc);
        end
      end else if (q_big.size() != 0 && q_big[0].cyc <= cyc) begin
        e = q_big.pop_front();
        check("big_missing", {31'b0, rsp_valid}, 32'd1);
      end
    end
  end

  always @(negedge clk) begin
    rsp_t e;
    if (!rst) begin
      if (rsp_valid_s) begin
        if (q_sm.size() == 0) begin
          check("sm_unexp", {31'b0, rsp_valid_s}, 32'd0);
        end else begin
          e = q_sm.pop_front();
          check("sm_rdata", rsp_rdata_s, e.rdata);
          check("sm_err", {31'b0, rsp_err_s}, {31'b0, e.err});
          check("sm_lat", cyc, e.cyc);
        end
      end else if (q_sm.size() != 0 && q_sm[0].cyc <= cyc) begin
        e = q_sm.pop_front();
        check("sm_missing", {31'b0, rsp_valid_s}, 32'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    cyc       = 0;
    rst       = 1'b1;
    clr       = 1'b0;
    req_valid = 1'b0;
    req_wen   = 1'b0;
    req_be    = '0;
    req_addr  = '0;
    req_wdata = '0;
    zero_models();
    repeat (3) @(posedge clk);
    #1;
    check("rst_init_done", {31'b0, init_done}, 32'd0);
    check("rst_ready", {31'b0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'h0);
    check("rst_err", {31'b0, rsp_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_init(256, 200);

    send(1'b0, 4'h0, 8'h00, 32'h0, 1'b0);
    send(1'b0, 4'h0, 8'hFF, 32'h0, 1'b0);
    idle(2);

    send(1'b1, 4'b1111, 8'h10, 32'hDEADBEEF, 1'b0);
    send(1'b1, 4'b0011, 8'h10, 32'h00001122, 1'b0);
    send(1'b0, 4'h0, 8'h10, 32'h0, 1'b0);
    idle(1);
    check("hold_valid", {31'b0, rsp_valid}, 32'd0);
    check("hold_rdata", rsp_rdata, 32'hDEAD1122);
    idle(1);

    send(1'b1, 4'hF, 8'h20, 32'h11111111, 1'b0);
    send(1'b0, 4'h0, 8'h20, 32'h0, 1'b0);
    send(1'b1, 4'hF, 8'h21, 32'h22222222, 1'b0);
    send(1'b0, 4'h0, 8'h21, 32'h0, 1'b0);
    send(1'b1, 4'h0, 8'h21, 32'hFFFFFFFF, 1'b0);
    send(1'b0, 4'h0, 8'h21, 32'h0, 1'b0);
    idle(2);

    send(1'b1, 4'hF, 8'hC7, 32'h12345678, 1'b0);
    send(1'b1, 4'hF, 8'hC8, 32'hFFFFFFFF, 1'b0);
    send(1'b0, 4'h0, 8'hC8, 32'h0, 1'b0);
    send(1'b0, 4'h0, 8'hC7, 32'h0, 1'b0);
    idle(2);
    drain();

    send(1'b1, 4'hF, 8'h05, 32'hA5A5A5A5, 1'b1);
    req_valid = 1'b0;
    clr       = 1'b0;
    check("clr_init_done", {31'b0, init_done}, 32'd0);
    wait_init(256, 200);
    send(1'b0, 4'h0, 8'h05, 32'h0, 1'b0);
    send(1'b0, 4'h0, 8'h10, 32'h0, 1'b0);
    idle(2);
    drain();

    send(1'b1, 4'hF, 8'h30, 32'hCAFEF00D, 1'b0);
    send(1'b0, 4'h0, 8'h30, 32'h0, 1'b0);
    req_valid = 1'b0;
    check("inflight_valid", {31'b0, rsp_valid}, 32'd1);
    #2;
    rst = 1'b1;
    q_big.delete();
    q_sm.delete();
    zero_models();
    #1;
    check("arst_valid", {31'b0, rsp_valid}, 32'd0);
    check("arst_rdata", rsp_rdata, 32'h0);
    check("arst_init_done", {31'b0, init_done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_init(256, 200);
    send(1'b0, 4'h0, 8'h30, 32'h0, 1'b0);
    send(1'b0, 4'h0, 8'h10, 32'h0, 1'b0);
    idle(2);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
- Parametrised synchronous data memory with a valid/ready request port, per-byte write enables, registered read data and a response strobe.
- Replaces the fixed 256x32 data memory in the datapath; the load/store stage issues one request per cycle.
- A hardware clear sequencer zero-fills the array after reset and on demand, so no simulation-only initialisation is needed.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8.
- ADDR_W, 8, address width in bits (word addressing).
- DEPTH, 256, number of words implemented; must satisfy 1 <= DEPTH <= 2**ADDR_W.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  request to zero-fill the whole array; sampled only in IDLE.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_wen  in  1  1 = write, 0 = read.
- req_be  in  DATA_W/8  byte enables for writes; bit i covers bits [8i+7:8i].
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle pulse, one cycle after each accepted request.
- rsp_rdata  out  DATA_W  read data, qualified by rsp_valid.
- rsp_err  out  1  address out of range, qualified by rsp_valid.
- init_done  out  1  high while the array is fully cleared and usable (state IDLE).

Behaviour:
- States: INIT and IDLE.
  - rst asserted: state=INIT, clear counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0, req_ready=0.
  - Reset mid-operation: any in-flight response is discarded and the clear restarts from word 0.
- INIT:
  - Writes zero to word[cnt], then increments cnt; one word per cycle.
  - After writing word DEPTH-1, moves to IDLE. INIT lasts exactly DEPTH cycles.
  - req_ready=0 and no request is accepted; clr is ignored.
- IDLE:
  - req_ready=1 and init_done=1.
  - A request is accepted when req_valid && req_ready.
  - clr=1 in IDLE: any request accepted in the same cycle still executes and responds. State becomes INIT at the next edge with cnt=0, and init_done/req_ready drop in that following cycle.
- Accepted read, addr < DEPTH:
  - Next cycle: rsp_valid=1, rsp_rdata=mem[addr], rsp_err=0.
  - Latency is exactly 1 cycle.
- Accepted write, addr < DEPTH:
  - At the accept edge, each byte with req_be[i]=1 is updated and other bytes are preserved.
  - Next cycle: rsp_valid=1, rsp_rdata=0, rsp_err=0.
  - req_be all zero is a legal no-op write that still responds, with no error.
- Accepted request with addr >= DEPTH:
  - No array update.
  - Next cycle: rsp_valid=1, rsp_rdata=0, rsp_err=1.
- Throughput: one request per cycle, back-to-back; there is no response backpressure.
- Ordering:
  - A read accepted in the cycle after a write to the same address returns the new data.
  - A request's response is never reordered relative to other requests.
- Outside response cycles:
  - rsp_valid=0.
  - rsp_rdata and rsp_err hold their last values.
- No req_valid in IDLE: the array is unchanged and rsp_valid=0 next cycle.

Test Plan:
- Reset release, DEPTH=256: init_done=0 and req_ready=0 for exactly 256 cycles, then 1. A read of addr 0x00 and a read of 0xFF each return 0x00000000 with rsp_err=0.
- Full-word write then byte merge:
  - Write addr 0x10, data 0xDEADBEEF, be=4'b1111.
  - Write addr 0x10, data 0x00001122, be=4'b0011.
  - Read addr 0x10 -> rsp_rdata=0xDEAD1122.
  - Each response arrives exactly 1 cycle after acceptance.
- Back-to-back stream:
  - Write 0x20=0x11111111, read 0x20, write 0x21=0x22222222, read 0x21 on 4 consecutive cycles.
  - Expect 4 consecutive rsp_valid pulses; the reads return 0x11111111 and 0x22222222.
- Out of range, DEPTH=200 and ADDR_W=8:
  - Write 0xC8=0xFFFFFFFF -> rsp_err=1.
  - Read 0xC8 -> rsp_err=1, rdata=0.
  - Read 0xC7 -> previous contents, rsp_err=0.
- clr with a coincident write:
  - In IDLE, write 0x05=0xA5A5A5A5 with clr=1 in the same cycle -> write response next cycle; init_done low for the following 256 cycles.
  - After the clear, read 0x05 -> 0x00000000.
- Async reset mid-stream:
  - Assert rst between clock edges while a read is in flight.
  - rsp_valid must drop immediately.
  - After release the full INIT sequence repeats, and earlier data reads back as 0.
